mpsoc_ram_1r1w_arbiter: RTL and testbench
=========================================

// Module: mpsoc_ram_1r1w_arbiter
// PURPOSE
//  Shares one 1R1W inferrable RAM (registered read, byte-enable write) among NPORTS requesters.
//  Independent round-robin arbitration on the write and read ports; routes 1-cycle read data back to the winner.
//  Clears the whole array after reset before accepting any traffic.
//  Sits between AHB3 slave front-ends and the memory wrapper.
// PARAMETERS
//  NPORTS  4   number of requesters (>=2)
//  ABITS   10  RAM address width; depth = 2**ABITS
//  DBITS   32  data width; BBITS = (DBITS+7)/8 byte enables
// PORTS
//  clk_i        in   1             clock, all logic on rising edge
//  rst_i        in   1             asynchronous, active-high reset
//  init_done_o  out  1             high once the clear sweep has finished
//  wreq_i       in   NPORTS        per-port write request (hold until wgnt)
//  waddr_i      in   NPORTSxABITS  per-port write address
//  wdata_i      in   NPORTSxDBITS  per-port write data
//  wbe_i        in   NPORTSxBBITS  per-port byte enables
//  wgnt_o       out  NPORTS        one-hot write accept; the write commits this edge
//  rreq_i       in   NPORTS        per-port read request (hold until rgnt)
//  raddr_i      in   NPORTSxABITS  per-port read address
//  rgnt_o       out  NPORTS        one-hot read accept
//  rvalid_o     out  NPORTS        one-hot, 1 cycle after rgnt, for the same port
//  rdata_o      out  DBITS         read data, valid when any rvalid_o is set
//  ram_waddr_o/ram_din_o/ram_we_o/ram_be_o  out  ABITS/DBITS/1/BBITS  RAM write side
//  ram_raddr_o  out  ABITS         RAM read address
//  ram_dout_i   in   DBITS         RAM registered read data
// BEHAVIOUR
//  Reset: state=INIT, clr_cnt=0, wptr=rptr=0, init_done_o=0; gnt, rvalid and ram_we_o are 0; rdata_o=0.
//  FSM INIT: ram_we_o=1, ram_be_o=all-ones, ram_din_o=0, ram_waddr_o=clr_cnt.
//   clr_cnt increments each cycle. At clr_cnt==2**ABITS-1 go to RUN (exactly 2**ABITS cycles).
//   All gnt are 0 while in INIT.
//  FSM RUN: init_done_o=1. No return to INIT except through rst_i.
//  Write arb: combinational, round-robin from wptr. Winner w gets wgnt_o[w]=1.
//   RAM write fields are driven from port w in the same cycle.
//   wptr <= w+1, wrapping NPORTS-1 -> 0. wptr is unchanged when there is no request.
//  Read arb: same scheme with rptr. ram_raddr_o=raddr_i[r].
//   The winner id is registered; next cycle rvalid_o[id]=1 and rdata_o=ram_dout_i.
//  Full throughput: one write + one read grant per cycle; no grant depends on a ready from the RAM.
//  Same-cycle RAW (read and write of the same address): RAM returns the old data unless BYPASS is enabled.
//  Requester dropping its request before grant: legal; it simply loses its turn.
//  Reset mid-sweep or mid-read: in-flight rvalid is dropped and the sweep restarts at 0.
// CONFIGURATION
//  MPSOC_RAM_ARB_BYPASS_EN defined:
//   On a same-cycle address match, the write data/be are registered with the read.
//   rdata_o byte k = wbe ? wdata : ram_dout_i.
//  Not defined: no compare logic; rdata_o = ram_dout_i.
// STRUCTURE
//  Package mpsoc_ram_arb_pkg: state enum {INIT, RUN}; function clog2 for port-id width.
//  Sub-module mpsoc_rr_arbiter #(N): req, ptr -> one-hot gnt and id. Instantiated twice (write and read).
// TESTING
//  1. Reset, ABITS=4: 16 cycles of ram_we_o with addresses 0..15, then init_done_o=1.
//     Any read then returns 0x00000000.
//  2. NPORTS=4, all wreq held: wgnt_o sequence 0001,0010,0100,1000,0001.
//  3. Port2 writes 0xDEADBEEF @5 with be=0101; port0 then reads @5.
//     rvalid_o=0001 after 1 cycle, rdata_o=0x00AD00EF.
//  4. Ports 1 and 3 read 7 and 9 back-to-back: rvalid 0010 then 1000, data matches memory, no gaps.
//  5. Same cycle: write 0x12345678 @3 and read @3.
//     With BYPASS: rdata_o=0x12345678. Without BYPASS: old value.
//  6. Assert rst_i mid-sweep at clr_cnt=9: pending rvalid is dropped, sweep restarts at 0 after release.

Source files
------------

// File: rtl/mpsoc_ram_1r1w_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mpsoc_ram_arb_pkg
//   Shared types and helpers for the 1R1W RAM arbiter slice.
//   - arb_state_t : controller state (clear sweep, then normal traffic)
//   - clog2()     : bit width needed to hold a port index
// ----------------------------------------------------------------------------
package mpsoc_ram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    // Width of an index in the range 0..n-1 (at least 1 bit).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mpsoc_ram_1r1w_arbiter_rr.sv
// ----------------------------------------------------------------------------
// mpsoc_rr_arbiter
//   Combinational round-robin pick: the first requester found when scanning
//   upward (with wrap) from ptr_i wins.
//   Ports:
//     req_i   [N-1:0]    request vector
//     ptr_i   [IDW-1:0]  highest-priority port this cycle
//     gnt_o   [N-1:0]    one-hot grant (all zero when no request)
//     id_o    [IDW-1:0]  index of the granted port
//     valid_o            a grant was issued
// ----------------------------------------------------------------------------
module mpsoc_rr_arbiter
    import mpsoc_ram_arb_pkg::*;
#(
    parameter  int unsigned N   = 4,
    localparam int unsigned IDW = clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] id_o,
    output logic           valid_o
);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr_i) + i) % N;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                id_o       = IDW'(idx);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/mpsoc_ram_1r1w_arbiter.sv
// ----------------------------------------------------------------------------
// mpsoc_ram_1r1w_arbiter
//   Shares one 1R1W RAM (registered read, byte-enable write) among NPORTS
//   requesters with independent round-robin write and read arbitration.
//   After reset the whole array is cleared (2**ABITS cycles) before any
//   request is granted. Read data returns one cycle after the read grant,
//   tagged by a one-hot rvalid_o for the winning port.
//
//   Optional build macro: MPSOC_RAM_ARB_BYPASS_EN
//     When defined, a same-cycle write/read to the same address forwards the
//     written bytes into the returned read data.
//
//   Ports:
//     clk_i, rst_i                 clock, async active-high reset
//     init_done_o                  clear sweep finished
//     wreq_i/waddr_i/wdata_i/wbe_i per-port write requests (flattened)
//     wgnt_o                       one-hot write accept (commits this edge)
//     rreq_i/raddr_i               per-port read requests (flattened)
//     rgnt_o                       one-hot read accept
//     rvalid_o/rdata_o             read return, one cycle after rgnt_o
//     ram_*_o / ram_dout_i         RAM macro interface
// ----------------------------------------------------------------------------
module mpsoc_ram_1r1w_arbiter
    import mpsoc_ram_arb_pkg::*;
#(
    parameter  int unsigned NPORTS = 4,
    parameter  int unsigned ABITS  = 10,
    parameter  int unsigned DBITS  = 32,
    localparam int unsigned BBITS  = (DBITS + 7) / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    output logic                      init_done_o,

    input  logic [NPORTS-1:0]         wreq_i,
    input  logic [NPORTS*ABITS-1:0]   waddr_i,
    input  logic [NPORTS*DBITS-1:0]   wdata_i,
    input  logic [NPORTS*BBITS-1:0]   wbe_i,
    output logic [NPORTS-1:0]         wgnt_o,

    input  logic [NPORTS-1:0]         rreq_i,
    input  logic [NPORTS*ABITS-1:0]   raddr_i,
    output logic [NPORTS-1:0]         rgnt_o,
    output logic [NPORTS-1:0]         rvalid_o,
    output logic [DBITS-1:0]          rdata_o,

    output logic [ABITS-1:0]          ram_waddr_o,
    output logic [DBITS-1:0]          ram_din_o,
    output logic                      ram_we_o,
    output logic [BBITS-1:0]          ram_be_o,
    output logic [ABITS-1:0]          ram_raddr_o,
    input  logic [DBITS-1:0]          ram_dout_i
);

    localparam int unsigned IDW = clog2(NPORTS);

    arb_state_t       state_q, state_d;
    logic [ABITS-1:0] clr_cnt_q, clr_cnt_d;
    logic [IDW-1:0]   wptr_q, wptr_d;
    logic [IDW-1:0]   rptr_q, rptr_d;
    logic             rvld_q, rvld_d;
    logic [IDW-1:0]   rid_q, rid_d;

    logic [NPORTS-1:0] w_gnt, r_gnt;
    logic [IDW-1:0]    w_id, r_id;
    logic              w_vld, r_vld;
    logic              run;
    logic              we_c;

    logic [ABITS-1:0] w_addr, r_addr;
    logic [DBITS-1:0] w_data;
    logic [BBITS-1:0] w_be;

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
        return (id == IDW'(NPORTS - 1)) ? '0 : id + 1'b1;
    endfunction

    mpsoc_rr_arbiter #(.N(NPORTS)) u_warb (
        .req_i   (wreq_i),
        .ptr_i   (wptr_q),
        .gnt_o   (w_gnt),
        .id_o    (w_id),
        .valid_o (w_vld)
    );

    mpsoc_rr_arbiter #(.N(NPORTS)) u_rarb (
        .req_i   (rreq_i),
        .ptr_i   (rptr_q),
        .gnt_o   (r_gnt),
        .id_o    (r_id),
        .valid_o (r_vld)
    );

    // Winner's fields, selected from the flattened port buses.
    assign w_addr = waddr_i[32'(w_id) * ABITS +: ABITS];
    assign w_data = wdata_i[32'(w_id) * DBITS +: DBITS];
    assign w_be   = wbe_i  [32'(w_id) * BBITS +: BBITS];
    assign r_addr = raddr_i[32'(r_id) * ABITS +: ABITS];

    assign run         = (state_q == ST_RUN);
    assign init_done_o = run;
    assign wgnt_o      = run ? w_gnt : '0;
    assign rgnt_o      = run ? r_gnt : '0;
    assign ram_raddr_o = r_addr;

    // The sweep write strobe is held off while reset is asserted so the RAM
    // sees no write until the controller is actually running the sweep.
    assign ram_we_o    = we_c & ~rst_i;

    assign rvalid_o    = rvld_q ? (NPORTS'(1) << rid_q) : '0;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        rvld_d      = 1'b0;
        rid_d       = rid_q;
        we_c        = 1'b0;
        ram_waddr_o = w_addr;
        ram_din_o   = w_data;
        ram_be_o    = w_be;

        case (state_q)
            ST_INIT: begin
                we_c        = 1'b1;
                ram_waddr_o = clr_cnt_q;
                ram_din_o   = '0;
                ram_be_o    = '1;
                clr_cnt_d   = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                we_c = w_vld;
                if (w_vld) begin
                    wptr_d = next_ptr(w_id);
                end
                if (r_vld) begin
                    rptr_d = next_ptr(r_id);
                    rvld_d = 1'b1;
                    rid_d  = r_id;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            rvld_q    <= 1'b0;
            rid_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            rvld_q    <= rvld_d;
            rid_q     <= rid_d;
        end
    end

`ifdef MPSOC_RAM_ARB_BYPASS_EN
    // Write bytes captured alongside a same-address read; they override the
    // (stale) RAM output when the read data returns.
    logic [BBITS-1:0] byp_be_q, byp_be_d;
    logic [DBITS-1:0] byp_data_q, byp_data_d;

    always_comb begin
        byp_data_d = w_data;
        byp_be_d   = '0;
        if (run && w_vld && r_vld && (w_addr == r_addr)) begin
            byp_be_d = w_be;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byp_be_q   <= '0;
            byp_data_q <= '0;
        end else begin
            byp_be_q   <= byp_be_d;
            byp_data_q <= byp_data_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (rvld_q) begin
            for (int unsigned b = 0; b < DBITS; b++) begin
                rdata_o[b] = byp_be_q[b / 8] ? byp_data_q[b] : ram_dout_i[b];
            end
        end
    end
`else
    always_comb begin
        rdata_o = '0;
        if (rvld_q) begin
            rdata_o = ram_dout_i;
        end
    end
`endif

endmodule

// File: tb/tb_mpsoc_ram_1r1w_arbiter.sv
module tb_mpsoc_ram_1r1w_arbiter;

    localparam int NP = 4;
    localparam int AB = 4;
    localparam int DB = 32;
    localparam int BB = 4;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              init_done;
    logic [NP-1:0]     wreq;
    logic [NP*AB-1:0]  waddr;
    logic [NP*DB-1:0]  wdata;
    logic [NP*BB-1:0]  wbe;
    logic [NP-1:0]     wgnt;
    logic [NP-1:0]     rreq;
    logic [NP*AB-1:0]  raddr;
    logic [NP-1:0]     rgnt;
    logic [NP-1:0]     rvalid;
    logic [DB-1:0]     rdata;
    logic [AB-1:0]     ram_waddr;
    logic [DB-1:0]     ram_din;
    logic              ram_we;
    logic [BB-1:0]     ram_be;
    logic [AB-1:0]     ram_raddr;
    logic [DB-1:0]     ram_dout;

    always #5 clk = ~clk;

    mpsoc_ram_1r1w_arbiter #(.NPORTS(NP), .ABITS(AB), .DBITS(DB)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .init_done_o (init_done),
        .wreq_i      (wreq),
        .waddr_i     (waddr),
        .wdata_i     (wdata),
        .wbe_i       (wbe),
        .wgnt_o      (wgnt),
        .rreq_i      (rreq),
        .raddr_i     (raddr),
        .rgnt_o      (rgnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .ram_waddr_o (ram_waddr),
        .ram_din_o   (ram_din),
        .ram_we_o    (ram_we),
        .ram_be_o    (ram_be),
        .ram_raddr_o (ram_raddr),
        .ram_dout_i  (ram_dout)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    // Behavioural RAM: registered read returns pre-write contents on a same-edge RAW.
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= merge(ram[ram_waddr], ram_din, ram_be);
        ram_dout <= ram[ram_raddr];
    end

    // Reference model state.
    int          n_err = 0;
    int          n_chk = 0;
    int          m_wptr, m_rptr;
    logic [31:0] m_mem [DEPTH];
    bit          pend;
    int          pend_port;
    logic [31:0] pend_data;

    // Round-robin rule: first requesting port at or after ptr, wrapping.
    function automatic int pick(input logic [3:0] req, input int ptr);
        for (int off = 0; off < NP; off++) begin
            if (req[(ptr + off) % NP]) return (ptr + off) % NP;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setw(input int p, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        waddr[p*AB +: AB] = a;
        wdata[p*DB +: DB] = d;
        wbe[p*BB +: BB]   = be;
    endtask

    task automatic setr(input int p, input logic [3:0] a);
        raddr[p*AB +: AB] = a;
    endtask

    // One RUN-mode cycle: check against the model, advance model, move to next negedge.
    task automatic cycle();
        int ew, er;
        logic [3:0] wa, ra, be;
        logic [31:0] wd, rd;
        #1;
        ew = pick(wreq, m_wptr);
        er = pick(rreq, m_rptr);
        chk("init_done", 32'(init_done), 32'd1);
        chk("wgnt", 32'(wgnt), (ew >= 0) ? (32'd1 << ew) : 32'd0);
        chk("rgnt", 32'(rgnt), (er >= 0) ? (32'd1 << er) : 32'd0);
        chk("rvalid", 32'(rvalid), pend ? (32'd1 << pend_port) : 32'd0);
        if (pend) chk("rdata", rdata, pend_data);
        wa = '0; wd = '0; be = '0;
        if (ew >= 0) begin
            wa = waddr[ew*AB +: AB];
            wd = wdata[ew*DB +: DB];
            be = wbe[ew*BB +: BB];
            chk("ram_we", 32'(ram_we), 32'd1);
            chk("ram_waddr", 32'(ram_waddr), 32'(wa));
            chk("ram_din", ram_din, wd);
            chk("ram_be", 32'(ram_be), 32'(be));
        end else begin
            chk("ram_we_idle", 32'(ram_we), 32'd0);
        end
        pend = (er >= 0);
        if (er >= 0) begin
            ra = raddr[er*AB +: AB];
            chk("ram_raddr", 32'(ram_raddr), 32'(ra));
            rd = m_mem[ra];
`ifdef MPSOC_RAM_ARB_BYPASS_EN
            if (ew >= 0 && wa == ra) rd = merge(rd, wd, be);
`endif
            pend_port = er;
            pend_data = rd;
            m_rptr = (er + 1) % NP;
        end
        if (ew >= 0) begin
            m_mem[wa] = merge(m_mem[wa], wd, be);
            m_wptr = (ew + 1) % NP;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Clear-sweep cycles: expect zero writes at successive addresses and no grants.
    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("sweep_we", 32'(ram_we), 32'd1);
            chk("sweep_addr", 32'(ram_waddr), 32'(i));
            chk("sweep_din", ram_din, 32'd0);
            chk("sweep_be", 32'(ram_be), 32'hF);
            chk("sweep_done", 32'(init_done), 32'd0);
            chk("sweep_wgnt", 32'(wgnt), 32'd0);
            chk("sweep_rgnt", 32'(rgnt), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic model_reset();
        m_wptr = 0;
        m_rptr = 0;
        pend   = 1'b0;
        for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
    endtask

    task automatic random_traffic(input int n);
        for (int c = 0; c < n; c++) begin
            for (int p = 0; p < NP; p++) begin
                setw(p, 4'($urandom), $urandom, 4'($urandom));
                setr(p, 4'($urandom));
            end
            wreq = 4'($urandom);
            rreq = 4'($urandom);
            cycle();
        end
        wreq = '0;
        rreq = '0;
        cycle();
    endtask

    initial begin
        rst = 1'b1;
        wreq = '0; waddr = '0; wdata = '0; wbe = '0;
        rreq = '0; raddr = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_wgnt", 32'(wgnt), 32'd0);
        chk("rst_rgnt", 32'(rgnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);

        // Sweep with all requests asserted: none may be granted.
        @(negedge clk);
        wreq = '1;
        rreq = '1;
        rst  = 1'b0;
        sweep(DEPTH);
        #1;
        chk("sweep_end_done", 32'(init_done), 32'd1);

        // Cleared memory reads back zero.
        wreq = '0;
        rreq = 4'b0001;
        setr(0, 4'd2);
        cycle();
        rreq = '0;
        #1;
        chk("clr_rvalid", 32'(rvalid), 32'h1);
        chk("clr_rdata", rdata, 32'h0);
        cycle();

        // Held write requests rotate through all ports.
        for (int i = 0; i < 5; i++) begin
            for (int p = 0; p < NP; p++) setw(p, 4'(8 + $urandom_range(0, 7)), $urandom, 4'($urandom));
            wreq = '1;
            #1;
            chk("wgnt_seq", 32'(wgnt), 32'd1 << (i % NP));
            cycle();
        end
        wreq = '0;

        // Partial-byte write then read from another port.
        wreq = 4'b0100;
        setw(2, 4'd5, 32'hDEADBEEF, 4'b0101);
        cycle();
        wreq = '0;
        rreq = 4'b0001;
        setr(0, 4'd5);
        cycle();
        rreq = '0;
        #1;
        chk("be_rvalid", 32'(rvalid), 32'h1);
        chk("be_rdata", rdata, 32'h00AD00EF);
        cycle();

        // Back-to-back reads from ports 1 and 3.
        wreq = 4'b0001;
        setw(0, 4'd7, $urandom, 4'hF);
        cycle();
        wreq = 4'b0010;
        setw(1, 4'd9, $urandom, 4'hF);
        cycle();
        wreq = '0;
        rreq = 4'b1010;
        setr(1, 4'd7);
        setr(3, 4'd9);
        #1;
        chk("b2b_rgnt0", 32'(rgnt), 32'b0010);
        cycle();
        rreq = 4'b1000;
        #1;
        chk("b2b_rvalid0", 32'(rvalid), 32'b0010);
        chk("b2b_rdata0", rdata, m_mem[7]);
        cycle();
        rreq = '0;
        #1;
        chk("b2b_rvalid1", 32'(rvalid), 32'b1000);
        chk("b2b_rdata1", rdata, m_mem[9]);
        cycle();

        // Same-cycle write and read of one address.
        wreq = 4'b0001;
        setw(0, 4'd3, 32'hCAFEF00D, 4'hF);
        cycle();
        wreq = 4'b0001;
        setw(0, 4'd3, 32'h12345678, 4'hF);
        rreq = 4'b0010;
        setr(1, 4'd3);
        cycle();
        wreq = '0;
        rreq = '0;
        #1;
`ifdef MPSOC_RAM_ARB_BYPASS_EN
        chk("raw_same", rdata, 32'h12345678);
`else
        chk("raw_same", rdata, 32'hCAFEF00D);
`endif
        cycle();

        random_traffic(300);

        // Reset with a read granted but not yet returned.
        rreq = 4'b0100;
        setr(2, 4'($urandom));
        #1;
        chk("inflight_rgnt", 32'(rgnt), 32'b0100);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("inflight_rvalid", 32'(rvalid), 32'd0);
        chk("inflight_we", 32'(ram_we), 32'd0);
        rreq = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Reset again mid-sweep at clear count 9; sweep restarts from 0.
        sweep(9);
        #1;
        chk("mid_addr9", 32'(ram_waddr), 32'd9);
        rst = 1'b1;
        #1;
        chk("mid_we", 32'(ram_we), 32'd0);
        chk("mid_done", 32'(init_done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sweep(DEPTH);
        model_reset();
        random_traffic(60);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
